// File: rtl/msp430_trace_arbiter_if.sv
// rtl/msp430_trace_arbiter_if.sv - valid/ready trace record port shared by the arbiter and its consumer
interface msp430_trace_arbiter_if #(
  parameter int SEQ_W = 8
);
  logic             trc_valid;
  logic             trc_ready;
  logic             trc_core;
  logic [15:0]      trc_pc;
  logic [15:0]      trc_ir;
  logic             trc_irq;
  logic [SEQ_W-1:0] trc_seq;
  logic             trc_lost;

  modport master (
    output trc_valid, trc_core, trc_pc, trc_ir, trc_irq, trc_seq, trc_lost,
    input  trc_ready
  );

  modport slave (
    input  trc_valid, trc_core, trc_pc, trc_ir, trc_irq, trc_seq, trc_lost,
    output trc_ready
  );
endinterface

// File: rtl/msp430_trace_arbiter.sv
// rtl/msp430_trace_arbiter.sv - per-core trace FIFOs round-robin merged onto one valid/ready trace port
module msp430_trace_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2,
  parameter int SEQ_W      = 8
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [1:0]  core_en,
  input  logic        core0_decode,
  input  logic [15:0] core0_pc,
  input  logic [15:0] core0_ir,
  input  logic        core0_irq,
  input  logic        core1_decode,
  input  logic [15:0] core1_pc,
  input  logic [15:0] core1_ir,
  input  logic        core1_irq,
  msp430_trace_arbiter_if.master trc,
  output logic [7:0]  drop_cnt0,
  output logic [7:0]  drop_cnt1
);

  typedef struct packed {
    logic [15:0]      pc;
    logic [15:0]      ir;
    logic             irq;
    logic [SEQ_W-1:0] seq;
    logic             lost;
  } rec_t;

  typedef enum logic {EMPTY, HOLD} state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  rec_t             mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [PTR_W:0]   cnt [2];
  logic [SEQ_W-1:0] seq_cnt [2];
  logic [7:0]       drop_cnt [2];
  logic [1:0]       lost_pend;
  logic             last_grant;
  state_t           state;

  rec_t       in_rec [2];
  rec_t       head [2];
  rec_t       sel;
  logic [1:0] cap, ne, full, grant, push, drop;
  logic       arb_en;

  always_comb begin
    cap       = {core1_decode & core_en[1], core0_decode & core_en[0]};
    in_rec[0] = '{pc: core0_pc, ir: core0_ir, irq: core0_irq, seq: seq_cnt[0], lost: lost_pend[0]};
    in_rec[1] = '{pc: core1_pc, ir: core1_ir, irq: core1_irq, seq: seq_cnt[1], lost: lost_pend[1]};
    for (int c = 0; c < 2; c++) begin
      ne[c]   = (cnt[c] != '0);
      full[c] = (cnt[c] == FULL_CNT);
      head[c] = mem[c][rd_ptr[c]];
    end
    // The holding register can only take a new record when empty or being consumed.
    arb_en   = (state == EMPTY) || trc.trc_ready;
    grant[0] = arb_en & ne[0] & (~ne[1] | last_grant);
    grant[1] = arb_en & ne[1] & (~ne[0] | ~last_grant);
    push     = cap & (~full | grant);
    drop     = cap & ~push;
    sel      = grant[1] ? head[1] : head[0];
  end

  always_ff @(posedge mclk) begin
    for (int c = 0; c < 2; c++) begin
      if (!puc_rst && push[c]) mem[c][wr_ptr[c]] <= in_rec[c];
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state         <= EMPTY;
      last_grant    <= 1'b1;
      lost_pend     <= '0;
      trc.trc_valid <= 1'b0;
      trc.trc_core  <= 1'b0;
      trc.trc_pc    <= '0;
      trc.trc_ir    <= '0;
      trc.trc_irq   <= 1'b0;
      trc.trc_seq   <= '0;
      trc.trc_lost  <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        rd_ptr[c]   <= '0;
        wr_ptr[c]   <= '0;
        cnt[c]      <= '0;
        seq_cnt[c]  <= '0;
        drop_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (cap[c]) seq_cnt[c] <= seq_cnt[c] + SEQ_W'(1);
        if (push[c]) begin
          wr_ptr[c]    <= wr_ptr[c] + PTR_W'(1);
          lost_pend[c] <= 1'b0;
        end else if (drop[c]) begin
          lost_pend[c] <= 1'b1;
          if (drop_cnt[c] != 8'hFF) drop_cnt[c] <= drop_cnt[c] + 8'd1;
        end
        if (grant[c]) rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        if (push[c] && !grant[c])      cnt[c] <= cnt[c] + (PTR_W+1)'(1);
        else if (!push[c] && grant[c]) cnt[c] <= cnt[c] - (PTR_W+1)'(1);
      end

      if (grant != 2'b00) begin
        state         <= HOLD;
        last_grant    <= grant[1];
        trc.trc_valid <= 1'b1;
        trc.trc_core  <= grant[1];
        trc.trc_pc    <= sel.pc;
        trc.trc_ir    <= sel.ir;
        trc.trc_irq   <= sel.irq;
        trc.trc_seq   <= sel.seq;
        trc.trc_lost  <= sel.lost;
      end else if (state == HOLD && trc.trc_ready) begin
        state         <= EMPTY;
        trc.trc_valid <= 1'b0;
      end
    end
  end

  assign drop_cnt0 = drop_cnt[0];
  assign drop_cnt1 = drop_cnt[1];

endmodule

// File: tb/tb_msp430_trace_arbiter.sv
// tb/tb_msp430_trace_arbiter.sv - scoreboard bench for the dual-core trace arbiter
module tb_msp430_trace_arbiter;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [1:0]  core_en;
  logic        core0_decode, core0_irq, core1_decode, core1_irq;
  logic [15:0] core0_pc, core0_ir, core1_pc, core1_ir;
  logic [7:0]  drop_cnt0, drop_cnt1;

  msp430_trace_arbiter_if #(.SEQ_W(8)) trc();

  msp430_trace_arbiter #(.FIFO_DEPTH(4), .PTR_W(2), .SEQ_W(8)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .core_en(core_en),
    .core0_decode(core0_decode), .core0_pc(core0_pc), .core0_ir(core0_ir), .core0_irq(core0_irq),
    .core1_decode(core1_decode), .core1_pc(core1_pc), .core1_ir(core1_ir), .core1_irq(core1_irq),
    .trc(trc), .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic        core;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        irq;
    logic [7:0]  seq;
    logic        lost;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rec(input logic core, input logic [15:0] pc, input logic [15:0] ir,
                            input logic irq, input logic [7:0] seq, input logic lost);
    exp_q.push_back('{core, pc, ir, irq, seq, lost});
  endtask

  function automatic rec_t cur_rec();
    return '{trc.trc_core, trc.trc_pc, trc.trc_ir, trc.trc_irq, trc.trc_seq, trc.trc_lost};
  endfunction

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle();
    core0_decode = 1'b0; core0_pc = '0; core0_ir = '0; core0_irq = 1'b0;
    core1_decode = 1'b0; core1_pc = '0; core1_ir = '0; core1_irq = 1'b0;
  endtask

  task automatic dec0(input logic [15:0] pc, input logic [15:0] ir, input logic irq);
    core0_decode = 1'b1; core0_pc = pc; core0_ir = ir; core0_irq = irq;
  endtask

  task automatic dec1(input logic [15:0] pc, input logic [15:0] ir, input logic irq);
    core1_decode = 1'b1; core1_pc = pc; core1_ir = ir; core1_irq = irq;
  endtask

  task automatic do_reset();
    puc_rst = 1'b1;
    idle();
    tick();
    tick();
    puc_rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    idle();
    trc.trc_ready = 1'b1;
    while ((exp_q.size() != 0 || trc.trc_valid) && n < 100) begin
      tick();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stability under backpressure.
  initial begin
    rec_t snap, got, e;
    bit   stall = 1'b0;
    forever begin
      @(negedge mclk);
      if (puc_rst) begin
        stall = 1'b0;
      end else begin
        got = cur_rec();
        if (stall) begin
          check("valid_held_under_stall", trc.trc_valid, 1);
          check("stable_under_stall", got, snap);
        end
        if (trc.trc_valid && trc.trc_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: got %0h expected none", got);
          end else begin
            e = exp_q.pop_front();
            check("record", got, e);
          end
        end
        stall = trc.trc_valid && !trc.trc_ready;
        snap  = got;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ir_v;
    int          n0;
    trc.trc_ready = 1'b1;
    core_en       = 2'b11;
    do_reset();
    check("reset_outputs", {trc.trc_valid, cur_rec()}, 0);
    check("reset_drops", {drop_cnt0, drop_cnt1}, 0);

    // Single record with latency check
    dec0(16'hF800, 16'h4303, 1'b0);
    expect_rec(1'b0, 16'hF800, 16'h4303, 1'b0, 8'd0, 1'b0);
    tick();
    idle();
    check("latency_edge_n", trc.trc_valid, 0);
    tick();
    check("latency_edge_n1", trc.trc_valid, 1);
    drain("single");

    // Round-robin tie
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_rec(1'b0, 16'h1000 + 16'(i), 16'h4000 + 16'(i), 1'b0, 8'(i), 1'b0);
      expect_rec(1'b1, 16'h2000 + 16'(i), 16'h5000 + 16'(i), i[0], 8'(i), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      dec0(16'h1000 + 16'(i), 16'h4000 + 16'(i), 1'b0);
      dec1(16'h2000 + 16'(i), 16'h5000 + 16'(i), i[0]);
      tick();
    end
    drain("round_robin");

    // Overflow and lost flag on core1
    do_reset();
    trc.trc_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_rec(1'b1, 16'h3000 + 16'(i), 16'h6000 + 16'(i), 1'b0, 8'(i), 1'b0);
    expect_rec(1'b1, 16'h3006, 16'h6006, 1'b0, 8'd6, 1'b1);
    expect_rec(1'b1, 16'h3007, 16'h6007, 1'b0, 8'd7, 1'b0);
    for (int i = 0; i < 6; i++) begin
      dec1(16'h3000 + 16'(i), 16'h6000 + 16'(i), 1'b0);
      tick();
    end
    check("overflow_drop_cnt1", drop_cnt1, 1);
    trc.trc_ready = 1'b1;
    dec1(16'h3006, 16'h6006, 1'b0);
    tick();
    dec1(16'h3007, 16'h6007, 1'b0);
    tick();
    drain("overflow");
    check("overflow_drop_cnt1_after", drop_cnt1, 1);

    // Full FIFO plus simultaneous pop on core0
    do_reset();
    trc.trc_ready = 1'b0;
    for (int i = 0; i < 6; i++) expect_rec(1'b0, 16'h7000 + 16'(i), 16'h7100 + 16'(i), 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      dec0(16'h7000 + 16'(i), 16'h7100 + 16'(i), 1'b0);
      tick();
    end
    trc.trc_ready = 1'b1;
    dec0(16'h7005, 16'h7105, 1'b0);
    tick();
    check("full_pop_drop_cnt0", drop_cnt0, 0);
    drain("full_pop");

    // Random backpressure on core0 traffic
    do_reset();
    n0 = 0;
    for (int i = 0; i < 60; i++) begin
      idle();
      trc.trc_ready = (i % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i % 3 == 0) begin
        ir_v = 16'($urandom);
        dec0(16'h8000 + 16'(i), ir_v, 1'(i % 2));
        expect_rec(1'b0, 16'h8000 + 16'(i), ir_v, 1'(i % 2), 8'(n0), 1'b0);
        n0++;
      end
      tick();
    end
    drain("backpressure");
    check("backpressure_drops", drop_cnt0, 0);

    // Reset mid-operation with drops and both FIFOs occupied
    do_reset();
    trc.trc_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      idle();
      dec0(16'h9000 + 16'(i), 16'h9100, 1'b0);
      if (i < 2) dec1(16'hA000 + 16'(i), 16'hA100, 1'b1);
      tick();
    end
    check("pre_reset_valid", trc.trc_valid, 1);
    check("pre_reset_drop_cnt0", drop_cnt0, 2);
    trc.trc_ready = 1'b1;
    puc_rst = 1'b1;
    idle();
    tick();
    check("midreset_outputs", {trc.trc_valid, cur_rec()}, 0);
    check("midreset_drops", {drop_cnt0, drop_cnt1}, 0);
    puc_rst = 1'b0;
    tick();
    tick();
    check("post_reset_empty", trc.trc_valid, 0);

    // Core0 disabled: strobes ignored entirely
    core_en = 2'b10;
    expect_rec(1'b1, 16'h5000, 16'h5555, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      dec0(16'hB000 + 16'(i), 16'hB100, 1'b0);
      if (i == 0) dec1(16'h5000, 16'h5555, 1'b0);
      tick();
    end
    drain("disabled");
    check("disabled_drop_cnt0", drop_cnt0, 0);
    core_en = 2'b11;
    expect_rec(1'b0, 16'h6000, 16'h6666, 1'b0, 8'd0, 1'b0);
    dec0(16'h6000, 16'h6666, 1'b0);
    tick();
    drain("reenabled");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
